// File: rtl/wave_dump_uart.sv
// wave_dump_uart: freezes the capture RAM and streams A5 5A, DEPTH samples and an 8-bit sum checksum out as 8N1 UART.
module wave_dump_uart #(
  parameter int BAUD_DIV = 868,
  parameter int DEPTH = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk100,
  input  logic              clr_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              freeze,
  output logic              txd,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(DEPTH + 4);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH + 2);
  localparam logic [CW-1:0] LAST_SAMPLE_PRED = CW'(DEPTH);
  localparam logic [BW-1:0] RELOAD = BW'(BAUD_DIV - 1);
  typedef enum logic [2:0] {IDLE, PREP1, PREP2, SHIFT, DONE} state_t;
  state_t state;
  logic start_d;
  logic [CW-1:0] idx;
  logic [BW-1:0] baud;
  logic [3:0] bit_idx;
  logic [7:0] sh, ck;
  always_ff @(posedge clk100) begin
    if (!clr_n) begin
      state <= IDLE;
      start_d <= 1'b1;
      txd <= 1'b1;
      busy <= 1'b0;
      freeze <= 1'b0;
      done <= 1'b0;
      rd_addr <= '0;
      ck <= '0;
      idx <= '0;
      baud <= '0;
      bit_idx <= '0;
      sh <= '0;
    end else begin
      start_d <= start;
      done <= 1'b0;
      case (state)
        IDLE: if (start && !start_d) begin
          state <= PREP1;
          busy <= 1'b1;
          freeze <= 1'b1;
          idx <= '0;
          ck <= '0;
        end
        PREP1: state <= PREP2;
        PREP2: begin
          state <= SHIFT;
          txd <= 1'b0;
          bit_idx <= '0;
          baud <= RELOAD;
          sh <= idx == 0 ? 8'hA5 : idx == 1 ? 8'h5A : idx == LAST ? ck : rd_data;
          if (idx >= 2 && idx < LAST) ck <= ck + rd_data;
        end
        SHIFT: begin
          if (baud != 0) baud <= baud - 1'b1;
          else if (bit_idx == 4'd9) begin
            txd <= 1'b1;
            if (idx == LAST) begin
              state <= DONE;
              done <= 1'b1;
              busy <= 1'b0;
              freeze <= 1'b0;
              rd_addr <= '0;
            end else begin
              state <= PREP1;
              idx <= idx + 1'b1;
              // the next byte is a sample: present its address one cycle before latching rd_data
              if (idx >= 1 && idx <= LAST_SAMPLE_PRED) rd_addr <= ADDR_W'(idx - 1'b1);
            end
          end else begin
            baud <= RELOAD;
            bit_idx <= bit_idx + 1'b1;
            txd <= bit_idx == 4'd8 ? 1'b1 : sh[0];
            sh <= sh >> 1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wave_dump_uart.sv
// tb_wave_dump_uart: directed frames with random RAM contents, checked cycle by cycle against a timing formula model.
module tb_wave_dump_uart;
  localparam int BAUD_DIV = 4;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 3;
  localparam int BYTE_T = 10 * BAUD_DIV + 2;
  localparam int FRAME_T = (DEPTH + 3) * BYTE_T;
  logic clk100 = 1'b0;
  logic clr_n = 1'b0;
  logic start = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic freeze, txd, busy, done;
  logic [7:0] mem [8];
  logic [7:0] exp_b [DEPTH+3];
  int total = 0;
  int bad = 0;

  wave_dump_uart #(.BAUD_DIV(BAUD_DIV), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk100(clk100), .clr_n(clr_n), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .freeze(freeze), .txd(txd), .busy(busy), .done(done)
  );

  always #5 clk100 = ~clk100;
  always @(posedge clk100) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic build_expect();
    int s = 0;
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h5A;
    for (int i = 0; i < DEPTH; i++) begin
      exp_b[i+2] = mem[i];
      s += mem[i];
    end
    exp_b[DEPTH+2] = 8'(s % 256);
  endtask

  function automatic logic exp_txd(input int c);
    int k, p, b;
    logic [7:0] v;
    if (c < 1 || c > FRAME_T) return 1'b1;
    k = (c - 1) / BYTE_T;
    p = (c - 1) % BYTE_T;
    if (p < 2) return 1'b1;
    b = (p - 2) / BAUD_DIV;
    v = exp_b[k];
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : v[b-1];
  endfunction

  function automatic int exp_addr(input int c);
    int k;
    if (c < 1 || c > FRAME_T) return 0;
    k = (c - 1) / BYTE_T;
    return k < 2 ? 0 : k < DEPTH + 2 ? k - 2 : DEPTH - 1;
  endfunction

  // Cycle 1 is the first cycle after the accepting edge.
  task automatic run_frame(input int abort_at, input bit poke_busy);
    start = 1'b1;
    step();
    for (int c = 1; c <= FRAME_T + 6; c++) begin
      check("txd", c, 32'(txd), 32'(exp_txd(c)));
      check("busy", c, 32'(busy), 32'(c <= FRAME_T));
      check("freeze", c, 32'(freeze), 32'(c <= FRAME_T));
      check("done", c, 32'(done), 32'(c == FRAME_T + 1));
      check("rd_addr", c, 32'(rd_addr), 32'(exp_addr(c)));
      if (c == 2) start = 1'b0;
      if (poke_busy && c == 2 * BYTE_T + 10) start = 1'b1;
      if (poke_busy && c == 2 * BYTE_T + 14) start = 1'b0;
      if (c == abort_at) begin
        clr_n = 1'b0;
        step();
        check("abort_txd", c + 1, 32'(txd), 32'd1);
        check("abort_busy", c + 1, 32'(busy), 32'd0);
        check("abort_freeze", c + 1, 32'(freeze), 32'd0);
        check("abort_done", c + 1, 32'(done), 32'd0);
        clr_n = 1'b1;
        step();
        return;
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    start = 1'b1;
    clr_n = 1'b0;
    repeat (3) step();
    check("rst_txd", 0, 32'(txd), 32'd1);
    check("rst_busy", 0, 32'(busy), 32'd0);
    check("rst_freeze", 0, 32'(freeze), 32'd0);
    check("rst_done", 0, 32'(done), 32'd0);
    check("rst_addr", 0, 32'(rd_addr), 32'd0);
    clr_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("held_start_busy", i, 32'(busy), 32'd0);
      check("held_start_txd", i, 32'(txd), 32'd1);
      check("held_start_freeze", i, 32'(freeze), 32'd0);
    end
    start = 1'b0;
    step();
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'hF0;
    build_expect();
    check("ck_basic", 0, 32'(exp_b[DEPTH+2]), 32'h50);
    run_frame(-1, 1'b0);
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
    build_expect();
    check("ck_wrap", 0, 32'(exp_b[DEPTH+2]), 32'hFC);
    run_frame(-1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
      build_expect();
      run_frame(-1, 1'b1);
      run_frame(-1, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
    build_expect();
    run_frame(1 + 3 * BYTE_T + 2 + 4 * BAUD_DIV + 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("post_abort_idle", i, 32'(busy), 32'd0);
      step();
    end
    run_frame(-1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
